// File: rtl/mpy_dot_acc.sv
// Issue controller and dot-product accumulator for the 8x8 unsigned pipelined multiplier.
// Pairs are pushed into MPY; a {valid,last} tag pipeline tracks each term to the product output.
module mpy_dot_acc #(
  parameter int LAT       = 8,
  parameter int MAX_TERMS = 16,
  parameter int ACC_W     = 20,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic [7:0]       mpy_a,
  output logic [7:0]       mpy_b,
  input  logic [15:0]      mpy_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [1:0] S_ACCEPT = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  logic [1:0]       r_state;
  logic [7:0]       r_mpy_a;
  logic [7:0]       r_mpy_b;
  logic [CNT_W-1:0] r_in_cnt;
  logic [CNT_W-1:0] r_acc_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic [LAT:0]     r_tag_v;
  logic [LAT:0]     r_tag_l;

  logic             w_xfer;
  logic             w_eff_last;
  logic             w_retire;
  logic             w_retire_last;
  logic [ACC_W-1:0] w_acc_next;

  assign in_ready      = (r_state == S_ACCEPT);
  assign w_xfer        = in_valid & in_ready;
  // The term that fills the sum to MAX_TERMS closes it even without in_last.
  assign w_eff_last    = in_last | (r_in_cnt == CNT_W'(MAX_TERMS - 1));
  assign w_retire      = r_tag_v[LAT];
  assign w_retire_last = r_tag_v[LAT] & r_tag_l[LAT];
  assign w_acc_next    = r_acc + {{(ACC_W-16){1'b0}}, mpy_p};

  assign mpy_a     = r_mpy_a;
  assign mpy_b     = r_mpy_b;
  assign out_valid = (r_state == S_HOLD);
  assign out_sum   = r_sum;
  assign out_count = r_count;

  // Issue side: operand registers, tag pipeline and input term count.
  // NOTE: every sequential assignment uses <= so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mpy_a  <= '0;
      r_mpy_b  <= '0;
      r_in_cnt <= '0;
      // NOTE: the tag pipeline is reset (unlike a data-only pipe) so stale terms never retire.
      r_tag_v  <= '0;
      r_tag_l  <= '0;
    end else begin
      if (w_xfer) begin
        r_mpy_a  <= in_a;
        r_mpy_b  <= in_b;
        r_in_cnt <= w_eff_last ? '0 : r_in_cnt + CNT_W'(1);
      end
      r_tag_v <= {r_tag_v[LAT-1:0], w_xfer};
      r_tag_l <= {r_tag_l[LAT-1:0], w_xfer & w_eff_last};
    end
  end

  // Retire side: accumulate products aligned with tag[LAT].
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_acc_cnt <= '0;
      r_sum     <= '0;
      r_count   <= '0;
    end else if (w_retire) begin
      if (r_tag_l[LAT]) begin
        r_sum     <= w_acc_next;
        r_count   <= r_acc_cnt + CNT_W'(1);
        r_acc     <= '0;
        r_acc_cnt <= '0;
      end else begin
        r_acc     <= w_acc_next;
        r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_ACCEPT;
    end else begin
      case (r_state)
        S_ACCEPT: if (w_xfer && w_eff_last) r_state <= S_DRAIN;
        S_DRAIN:  if (w_retire_last)        r_state <= S_HOLD;
        S_HOLD:   if (out_ready)            r_state <= S_ACCEPT;
        default:                            r_state <= S_ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_mpy_dot_acc.sv
// Self-checking bench for mpy_dot_acc: behavioural MPY model plus a sum/count scoreboard.
module tb_mpy_dot_acc;

  localparam int LAT   = 8;
  localparam int ACC_W = 20;
  localparam int CNT_W = 5;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic [7:0]       mpy_a;
  logic [7:0]       mpy_b;
  logic [15:0]      mpy_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_xfer_cyc = 0;
  bit   ov_prev = 1'b0;
  bit   ov_seen = 1'b0;
  exp_t sb_q[$];
  int   mdl_sum = 0;
  int   mdl_cnt = 0;
  logic [15:0] mpy_pipe [LAT];

  mpy_dot_acc dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mpy_a(mpy_a), .mpy_b(mpy_b), .mpy_p(mpy_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // MPY model: product of the registered operands appears LAT cycles later.
  always @(posedge clk) begin
    mpy_pipe[0] <= 16'(mpy_a) * 16'(mpy_b);
    for (int i = 1; i < LAT; i++) mpy_pipe[i] <= mpy_pipe[i-1];
  end
  assign mpy_p = mpy_pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: latency of every sum and scoreboard compare on each handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) ov_seen = 1'b1;
        if (out_valid && !ov_prev) check("latency", 32'(cyc - last_xfer_cyc), 32'(LAT + 1));
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) check("spurious_out_valid", 32'd1, 32'd0);
          else begin
            e = sb_q.pop_front();
            check("out_sum", 32'(out_sum), 32'(e.sum));
            check("out_count", 32'(out_count), 32'(e.cnt));
          end
        end
        ov_prev = out_valid;
      end else begin
        ov_prev = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) check("send_timeout", 32'd0, 32'd1);
    tick();
    last_xfer_cyc = cyc;
    in_valid = 1'b0;
    mdl_sum += int'(a) * int'(b);
    mdl_cnt++;
    if (last || mdl_cnt == 16) begin
      sb_q.push_back('{sum: ACC_W'(mdl_sum), cnt: CNT_W'(mdl_cnt)});
      mdl_sum = 0;
      mdl_cnt = 0;
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (n >= 50) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    wait_valid();
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_mpy_a", 32'(mpy_a), 32'd0);
    check("rst_mpy_b", 32'(mpy_b), 32'd0);

    // Single maximal term with delayed out_ready.
    out_ready = 1'b0;
    send(8'd255, 8'd255, 1'b1);
    check("single_mpy_a", 32'(mpy_a), 32'd255);
    check("single_ready_low", 32'(in_ready), 32'd0);
    wait_valid();
    tick(); tick();
    check("single_hold_sum", 32'(out_sum), 32'd65025);
    check("single_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    check("single_ready_same_cycle", 32'(in_ready), 32'd0);
    tick();
    check("single_ready_after", 32'(in_ready), 32'd1);
    check("single_valid_dropped", 32'(out_valid), 32'd0);

    // Four back-to-back terms.
    for (int i = 0; i < 4; i++) begin
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      send(8'(2*i + 1), 8'(2*i + 2), i == 3);
    end
    wait_done();

    // Forced termination at MAX_TERMS.
    for (int i = 0; i < 16; i++) send(8'd255, 8'd255, 1'b0);
    check("forced_ready_low", 32'(in_ready), 32'd0);
    wait_done();

    // Output backpressure with in_valid held high.
    out_ready = 1'b0;
    send(8'd6, 8'd7, 1'b1);
    wait_valid();
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_sum_stable", 32'(out_sum), 32'd42);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_no_accept", 32'(mpy_a), 32'd6);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_ready_rises", 32'(in_ready), 32'd1);

    // Reset mid-drain: pending sum must vanish.
    send(8'd10, 8'd10, 1'b0);
    send(8'd20, 8'd20, 1'b1);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb_q.delete();
    mdl_sum = 0; mdl_cnt = 0;
    ov_seen = 1'b0;
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    check("rst2_out_sum", 32'(out_sum), 32'd0);
    check("rst2_out_count", 32'(out_count), 32'd0);
    check("rst2_mpy_a", 32'(mpy_a), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    check("rst2_no_out_valid", 32'(ov_seen), 32'd0);
    send(8'd2, 8'd3, 1'b1);
    wait_done();

    // Zero operand and idle gaps.
    send(8'd0, 8'd200, 1'b0);
    tick(); tick(); tick();
    send(8'd15, 8'd17, 1'b1);
    wait_done();

    tick(); tick();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mpy_dot_acc.md
Name: mpy_dot_acc

Overview:
- Downstream consumer and issue controller for the 8-bit unsigned pipelined array multiplier (MPY).
- Accepts a stream of operand pairs over a valid/ready handshake and drives them into MPY, one pair per cycle.
- Tracks each pair through MPY's fixed latency with a tag pipeline and accumulates the 16-bit products.
- Presents the dot-product sum over a valid/ready output handshake when the last term is reached.

Parameters:
- LAT, 8: cycles from mpy_a/mpy_b visible at the MPY inputs to the matching mpy_p visible at the MPY output.
- MAX_TERMS, 16: maximum terms per sum. The term that brings the count to MAX_TERMS is treated as last.
- ACC_W, 20: accumulator/sum width. Must be at least 16 + clog2(MAX_TERMS).
- CNT_W, 5: term-count width. Must be at least clog2(MAX_TERMS+1).

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept a pair this cycle
- in_a  input  8  multiplicand
- in_b  input  8  multiplier
- in_last  input  1  this pair is the final term of the sum
- mpy_a  output  8  registered operand to MPY a
- mpy_b  output  8  registered operand to MPY b
- mpy_p  input  16  MPY product
- out_valid  output  1  sum valid
- out_ready  input  1  consumer accepts the sum
- out_sum  output  ACC_W  accumulated sum
- out_count  output  CNT_W  number of terms in out_sum

Behaviour:
- Reset: rst_n is synchronous and active-low, sampled on posedge clk. Reset values:
  - state=ACCEPT, in_ready=1, out_valid=0, out_sum=0, out_count=0
  - mpy_a=0, mpy_b=0, acc=0, term count=0
  - all tag-pipeline entries invalid
- Reset mid-operation discards every in-flight tag and partial sum. No out_valid pulse may follow from pre-reset terms.
- Handshake: a pair transfers on a posedge where in_valid & in_ready. in_ready is 1 exactly when state==ACCEPT.
- Issue: on a transfer at cycle t, mpy_a/mpy_b take in_a/in_b (visible in cycle t+1). They hold their value when no transfer occurs.
- Tag pipeline: LAT+1 entries, each holding {valid, last}. Entry 0 is loaded at the transfer edge. Entry k is visible in cycle t+1+k; entry LAT aligns with the matching mpy_p.
  - eff_last = in_last OR (term count == MAX_TERMS-1).
  - A cycle with no transfer inserts an invalid tag.
- Accumulate: in any cycle where tag[LAT].valid is set, mpy_p is zero-extended to ACC_W and added.
  - Not last: acc <= acc + mpy_p.
  - Last: out_sum <= acc + mpy_p, out_count <= terms in this sum, out_valid <= 1, acc <= 0.
- Term count increments on each transfer. It clears on the transfer carrying eff_last.
- FSM:
  - ACCEPT -> DRAIN on a transfer with eff_last. Back-to-back transfers at one per cycle are allowed in ACCEPT.
  - DRAIN (in_ready=0) -> HOLD on the edge where tag[LAT] is valid and last.
  - HOLD (out_valid=1): out_sum/out_count are held stable until out_ready. On out_valid & out_ready: out_valid <= 0, -> ACCEPT.
  - in_ready rises the cycle after the output handshake, never in the same cycle.
- Latency: last transfer at edge t -> out_valid high in cycle t+2+LAT (10 cycles with defaults).
- Arithmetic: unsigned only. The ACC_W bound guarantees no overflow. No saturation or wrap logic.
- in_valid is ignored while in_ready=0. in_a/in_b/in_last are don't-care when in_valid=0.
- Simultaneous events: rst_n low overrides every handshake in the same cycle.

Test Plan:
- Single term: in_a=255, in_b=255, in_last=1 -> out_valid 10 cycles later, out_sum=65025, out_count=1. in_ready stays 0 until the cycle after out_ready.
- Four back-to-back terms (1,2),(3,4),(5,6),(7,8), last on the 4th -> in_ready=1 for all four cycles, out_sum=100, out_count=4.
- Forced termination: 16 pairs of (255,255) with in_last=0 -> 16th treated as last, in_ready drops, out_sum=1040400 (0xFE010), out_count=16.
- Output backpressure: complete a sum of 42 (6*7) and hold out_ready=0 for 5 cycles while in_valid=1 -> out_sum stable at 42, in_ready=0, no pairs accepted. Raise out_ready -> in_ready=1 the next cycle.
- Reset mid-drain: issue (10,10),(20,20) with last, then rst_n=0 for 1 cycle at 3 cycles after the last transfer -> no out_valid ever, all outputs at reset values. Next sum (2,3) last -> out_sum=6, out_count=1.
- Zero operands/idle gaps: (0,200), gap of 3 cycles, (15,17) last -> out_sum=255, out_count=2. Idle cycles add nothing.
